aes256_key_schedule: RTL

Multicycle AES-256 key-expansion engine that sits directly upstream of `aes_encryption`. It accepts a 256-bit cipher key over a valid/ready handshake and generates the 60 FIPS-197 schedule words, one word per clock. It presents the full 15-round-key chain (1920 bits) for the cipher datapath to consume. Area is traded for latency: one shared SubWord datapath of four S-boxes.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_sbox.sv | 35 +++
 rtl/aes256_key_schedule.sv | 118 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, sizes, round constants and key-schedule FSM encoding.
// Also provides GF(2^8) multiply used by the S-box datapath.
package aes_pkg;

  typedef logic [31:0] aes_word_t;

  localparam int AES256_NK      = 8;
  localparam int AES256_NR      = 14;
  localparam int AES256_NW      = 60;
  localparam int AES256_CHAIN_W = 32 * AES256_NW;

  // Entry 0 is never selected: expansion starts at idx 8, i.e. idx[5:3] = 1
  localparam logic [7:0] AES_RCON [0:7] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } ks_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// followed by the FIPS-197 affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst
);

  // x^254 == x^-1 (and maps 0 to 0); 254 = 2+4+8+...+128
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv   = gf_inv(data);
    subst = inv
          ^ {inv[6:0], inv[7]}
          ^ {inv[5:0], inv[7:6]}
          ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]}
          ^ 8'h63;
  end

endmodule

// File: rtl/aes256_key_schedule.sv
// Multicycle AES-256 key expansion, one schedule word per clock via a shared SubWord.
// Optional AES_KEY_SCHEDULE_ZEROIZE_EN clears the chain on the consumer handshake.
module aes256_key_schedule
  import aes_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [255:0]              key_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [AES256_CHAIN_W-1:0] key_chain_o,
  output logic                      v_o,
  input  logic                      yumi_i
);

  ks_state_t  state_reg, state_next;
  logic [5:0] idx_reg, idx_next;
  aes_word_t  words [0:AES256_NW-1];

  logic       load;
  logic       expand;
  logic [5:0] prev_idx;
  logic [5:0] back_idx;
  aes_word_t  prev_word;
  aes_word_t  back_word;
  aes_word_t  sub_in;
  aes_word_t  sub_out;
  aes_word_t  temp;
  aes_word_t  new_word;

  assign load    = (state_reg == ST_IDLE) && v_i;
  assign expand  = (state_reg == ST_EXPAND);
  assign ready_o = (state_reg == ST_IDLE);
  assign v_o     = (state_reg == ST_DONE);

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  logic consume;
  assign consume = (state_reg == ST_DONE) && yumi_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= ST_IDLE;
      idx_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (v_i) begin
          state_next = ST_EXPAND;
          idx_next   = 6'(AES256_NK);
        end
      end
      ST_EXPAND: begin
        if (idx_reg == 6'(AES256_NW - 1)) state_next = ST_DONE;
        else                              idx_next   = idx_reg + 6'd1;
      end
      ST_DONE: begin
        if (yumi_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Recurrence: w[idx] = w[idx-8] ^ f(w[idx-1])
  assign prev_idx  = idx_reg - 6'd1;
  assign back_idx  = idx_reg - 6'(AES256_NK);
  assign prev_word = words[prev_idx];
  assign back_word = words[back_idx];
  assign sub_in    = (idx_reg[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .data  (sub_in[8*gi +: 8]),
      .subst (sub_out[8*gi +: 8])
    );
  end

  always_comb begin
    temp = prev_word;
    if (idx_reg[2:0] == 3'd0)      temp = sub_out ^ {AES_RCON[idx_reg[5:3]], 24'h0};
    else if (idx_reg[2:0] == 3'd4) temp = sub_out;
    new_word = back_word ^ temp;
  end

  for (genvar gi = 0; gi < AES256_NW; gi++) begin : g_word
    aes_word_t word_reg;

    if (gi < AES256_NK) begin : g_key
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) word_reg <= '0;
        else if (load) word_reg <= key_i[255-32*gi -: 32];
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
        else if (consume) word_reg <= '0;
`endif
      end
    end else begin : g_exp
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) word_reg <= '0;
        else if (expand && (idx_reg == 6'(gi))) word_reg <= new_word;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
        else if (consume) word_reg <= '0;
`endif
      end
    end

    assign words[gi] = word_reg;
    assign key_chain_o[AES256_CHAIN_W-1-32*gi -: 32] = word_reg;
  end

endmodule
